// File: rtl/cr_kme_int_svc_pkg.sv
// Shared types and defaults for the KME interrupt servicer: FSM states,
// the layout of a log entry, and the default status register address.
package cr_kme_int_svc_pkg;

  localparam logic [15:0] INT_STATUS_ADDR_DEF = 16'h0040;
  localparam int          LOG_TS_W            = 32;
  localparam int          LOG_STATUS_W        = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_WR_REQ,
    ST_HOLD
  } svc_state_e;

  // Layout of log_data for the default widths: timestamp above status.
  typedef struct packed {
    logic [LOG_TS_W-1:0]     ts;
    logic [LOG_STATUS_W-1:0] status;
  } log_entry_t;

endpackage

// File: rtl/cr_kme_int_log_fifo.sv
// Synchronous FIFO for interrupt event records. The head word is presented
// combinationally so it is valid whenever the FIFO is non-empty.
module cr_kme_int_log_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/cr_kme_int_servicer.sv
// KME interrupt servicer: reads the interrupt status register, logs non-zero
// status with a timestamp, then write-1-clears exactly the bits it captured.
module cr_kme_int_servicer
  import cr_kme_int_svc_pkg::*;
#(
  parameter int                STATUS_W        = 5,
  parameter int                ADDR_W          = 16,
  parameter logic [ADDR_W-1:0] INT_STATUS_ADDR = ADDR_W'(INT_STATUS_ADDR_DEF),
  parameter int                LOG_DEPTH       = 8,
  parameter int                TS_W            = 32,
  parameter int                HOLDOFF         = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     kme_interrupt,
  output logic                     rd_stb,
  input  logic                     rd_ack,
  input  logic [31:0]              rd_data,
  output logic                     wr_stb,
  input  logic                     wr_ack,
  output logic [31:0]              wr_data,
  output logic [ADDR_W-1:0]        reg_addr,
  output logic                     log_valid,
  output logic [TS_W+STATUS_W-1:0] log_data,
  input  logic                     log_pop,
  output logic                     log_overflow,
  input  logic                     log_overflow_clr,
  output logic [15:0]              svc_count
);

  localparam int         ENTRY_W   = TS_W + STATUS_W;
  localparam int         CNT_W     = $clog2(LOG_DEPTH + 1);
  localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF - 1);

  svc_state_e        state_q;
  logic              rd_stb_q;
  logic              wr_stb_q;
  logic [31:0]       wr_data_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [3:0]        hold_cnt_q;
  logic [TS_W-1:0]   ts_q;
  logic [15:0]       svc_count_q;
  logic [15:0]       svc_count_d;
  logic              ovf_q;
  logic              ovf_d;

  logic [STATUS_W-1:0] rd_status;
  logic                capture;
  logic                push_req;
  logic                push_ok;
  logic                pop_req;
  logic                ovf_set;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  fifo_rdata;
  logic [CNT_W-1:0]    unused_fifo_count;
  logic                unused_rd_data;

  assign rd_status      = rd_data[STATUS_W-1:0];
  assign unused_rd_data = ^rd_data[31:STATUS_W];

  assign capture  = (state_q == ST_RD_REQ) && rd_ack;
  assign push_req = capture && (rd_status != '0);
  assign pop_req  = log_pop && !fifo_empty;
  // A full log still takes the entry when the head is consumed this cycle.
  assign push_ok  = push_req && (!fifo_full || log_pop);
  assign ovf_set  = push_req && !push_ok;

  assign svc_count_d = (push_req && (svc_count_q != 16'hFFFF)) ? svc_count_q + 16'd1
                                                               : svc_count_q;
  // Set wins over a coincident clear so no drop goes unreported.
  assign ovf_d = ovf_set || (ovf_q && !log_overflow_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_stb_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_data_q  <= '0;
      reg_addr_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable && kme_interrupt) begin
            state_q    <= ST_RD_REQ;
            rd_stb_q   <= 1'b1;
            reg_addr_q <= INT_STATUS_ADDR;
          end
        end
        ST_RD_REQ: begin
          if (rd_ack) begin
            rd_stb_q <= 1'b0;
            if (rd_status != '0) begin
              state_q   <= ST_WR_REQ;
              wr_stb_q  <= 1'b1;
              wr_data_q <= 32'(rd_status);
            end else begin
              state_q    <= ST_HOLD;
              hold_cnt_q <= HOLD_LAST;
              reg_addr_q <= '0;
            end
          end
        end
        ST_WR_REQ: begin
          if (wr_ack) begin
            state_q    <= ST_HOLD;
            wr_stb_q   <= 1'b0;
            wr_data_q  <= '0;
            reg_addr_q <= '0;
            hold_cnt_q <= HOLD_LAST;
          end
        end
        ST_HOLD: begin
          // Gives the handler time to drop its registered interrupt after the clear.
          if (hold_cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q - 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q        <= '0;
      svc_count_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      ts_q        <= ts_q + TS_W'(1);
      svc_count_q <= svc_count_d;
      ovf_q       <= ovf_d;
    end
  end

  cr_kme_int_log_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_ok),
    .pop_i   (pop_req),
    .wdata_i ({ts_q, rd_status}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_count)
  );

  assign rd_stb       = rd_stb_q;
  assign wr_stb       = wr_stb_q;
  assign wr_data      = wr_data_q;
  assign reg_addr     = reg_addr_q;
  assign log_valid    = !fifo_empty;
  assign log_data     = fifo_rdata;
  assign log_overflow = ovf_q;
  assign svc_count    = svc_count_q;

endmodule

// File: tb/tb_cr_kme_int_servicer.sv
// Randomized bench for cr_kme_int_servicer: a behavioural status register,
// bus responder and event-log queue predict every observable output.
module tb_cr_kme_int_servicer;
  import cr_kme_int_svc_pkg::*;

  localparam int HOLDOFF   = 4;
  localparam int LOG_DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        kme_interrupt = 1'b0;
  logic        rd_ack = 1'b0;
  logic [31:0] rd_data = '0;
  logic        wr_ack = 1'b0;
  logic        log_pop = 1'b0;
  logic        log_overflow_clr = 1'b0;
  logic        rd_stb;
  logic        wr_stb;
  logic [31:0] wr_data;
  logic [15:0] reg_addr;
  logic        log_valid;
  logic [36:0] log_data;
  logic        log_overflow;
  logic [15:0] svc_count;

  cr_kme_int_servicer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .kme_interrupt    (kme_interrupt),
    .rd_stb           (rd_stb),
    .rd_ack           (rd_ack),
    .rd_data          (rd_data),
    .wr_stb           (wr_stb),
    .wr_ack           (wr_ack),
    .wr_data          (wr_data),
    .reg_addr         (reg_addr),
    .log_valid        (log_valid),
    .log_data         (log_data),
    .log_pop          (log_pop),
    .log_overflow     (log_overflow),
    .log_overflow_clr (log_overflow_clr),
    .svc_count        (svc_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Abstract servicer phase: what the bus should be doing this cycle.
  typedef enum {M_IDLE, M_READ, M_WRITE, M_HOLD} mphase_e;

  mphase_e     ph = M_IDLE;
  int          hold_left = 0;
  int          rd_wait = 0;
  int          wr_wait = 0;
  logic [4:0]  status_reg = '0;
  logic [4:0]  pend_wr = '0;
  log_entry_t  logq[$];
  logic        ovf_m = 1'b0;
  int          svc_m = 0;
  logic [31:0] ts_m = '0;

  int pop_pct = 0, clr_pct = 0, evt_pct = 0, en_pct = 100, bimc_pct = 0;
  int ack_min = 0, ack_max = 3;

  task automatic step();
    log_entry_t got_e;
    logic       pop_now, clr_now, set_ovf;
    logic [4:0] st;
    logic [4:0] clear_bits;
    mphase_e    ph_n;

    check_val("rd_stb", rd_stb, ph == M_READ);
    check_val("wr_stb", wr_stb, ph == M_WRITE);
    check_val("strobe_excl", rd_stb & wr_stb, 0);
    if (ph == M_READ || ph == M_WRITE) check_val("reg_addr", reg_addr, 16'h0040);
    if (ph == M_WRITE) check_val("wr_data", wr_data, {27'b0, pend_wr});
    check_val("log_valid", log_valid, logq.size() != 0);
    if (logq.size() != 0) begin
      got_e = log_data;
      check_val("log_ts", got_e.ts, logq[0].ts);
      check_val("log_status", got_e.status, logq[0].status);
    end
    check_val("log_overflow", log_overflow, ovf_m);
    check_val("svc_count", svc_count, svc_m);

    if ($urandom_range(99) < evt_pct) status_reg = status_reg | (5'd1 << $urandom_range(4));
    enable        = ($urandom_range(99) < en_pct);
    kme_interrupt = (status_reg != 0) || ($urandom_range(99) < bimc_pct);
    pop_now       = ($urandom_range(99) < pop_pct);
    clr_now       = ($urandom_range(99) < clr_pct);
    log_pop          = pop_now;
    log_overflow_clr = clr_now;
    rd_ack  = 1'b0;
    wr_ack  = 1'b0;
    rd_data = $urandom;
    set_ovf = 1'b0;
    clear_bits = '0;
    ph_n = ph;

    if (pop_now && logq.size() != 0) void'(logq.pop_front());

    case (ph)
      M_IDLE: if (enable && kme_interrupt) begin
        ph_n = M_READ;
        rd_wait = $urandom_range(ack_max, ack_min);
      end
      M_READ: if (rd_wait == 0) begin
        st = status_reg;
        rd_ack = 1'b1;
        rd_data = ($urandom & ~32'h1f) | {27'b0, st};
        if (st != 0) begin
          if (logq.size() < LOG_DEPTH) logq.push_back('{ts: ts_m, status: st});
          else set_ovf = 1'b1;
          if (svc_m < 65535) svc_m++;
          pend_wr = st;
          ph_n = M_WRITE;
          wr_wait = $urandom_range(ack_max, ack_min);
        end else begin
          ph_n = M_HOLD;
          hold_left = HOLDOFF;
        end
      end else rd_wait--;
      M_WRITE: if (wr_wait == 0) begin
        wr_ack = 1'b1;
        clear_bits = pend_wr;
        ph_n = M_HOLD;
        hold_left = HOLDOFF;
      end else wr_wait--;
      default: begin
        hold_left--;
        if (hold_left == 0) ph_n = M_IDLE;
      end
    endcase

    ovf_m = set_ovf || (ovf_m && !clr_now);
    @(posedge clk);
    ts_m++;
    status_reg = status_reg & ~clear_bits;
    ph = ph_n;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    rd_ack = 1'b0;
    wr_ack = 1'b0;
    log_pop = 1'b0;
    log_overflow_clr = 1'b0;
    #1;
    check_val("rst_rd_stb", rd_stb, 0);
    check_val("rst_wr_stb", wr_stb, 0);
    check_val("rst_wr_data", wr_data, 0);
    check_val("rst_reg_addr", reg_addr, 0);
    check_val("rst_log_valid", log_valid, 0);
    check_val("rst_overflow", log_overflow, 0);
    check_val("rst_svc_count", svc_count, 0);
    logq.delete();
    svc_m = 0;
    ovf_m = 1'b0;
    ph = M_IDLE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ts_m = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int base;
    @(negedge clk);
    do_reset();

    // Single event, status 5, acks after two cycles.
    status_reg = 5'h05;
    en_pct = 100; evt_pct = 0; pop_pct = 0; ack_min = 2; ack_max = 2;
    run(25);
    check_val("t1_svc_count", svc_count, 1);
    check_val("t1_log_valid", log_valid, 1);

    // Interrupt with zero status: no log, no write.
    bimc_pct = 100;
    run(6);
    bimc_pct = 0;
    run(15);
    check_val("t2_svc_count", svc_count, 1);

    // Fill the log past capacity with no pops.
    ack_min = 0; ack_max = 3; evt_pct = 40;
    base = svc_m;
    for (int i = 0; i < 2000 && svc_m < base + 9; i++) step();
    check_val("t3_events_reached", svc_m >= base + 9, 1);
    evt_pct = 0; en_pct = 0;
    run(12);
    check_val("t3_overflow_set", log_overflow, 1);
    pop_pct = 100; run(1);
    pop_pct = 0; clr_pct = 100; run(1);
    clr_pct = 0; run(2);
    check_val("t3_overflow_clr", log_overflow, 0);
    check_val("t3_log_valid", log_valid, 1);

    // Full log with concurrent pops and pushes.
    en_pct = 100; evt_pct = 40; pop_pct = 15;
    run(600);

    // Broad random traffic, enable toggling, sporadic clears and zero reads.
    en_pct = 80; evt_pct = 10; pop_pct = 30; clr_pct = 5; bimc_pct = 3;
    run(3000);

    // Reset while a write waits for its ack.
    ack_min = 6; ack_max = 10; en_pct = 100; evt_pct = 30; bimc_pct = 0;
    for (int i = 0; i < 2000 && ph != M_WRITE; i++) step();
    check_val("t6_reached_write", ph == M_WRITE, 1);
    check_val("t6_pre_reset_wr_stb", wr_stb, 1);
    do_reset();
    ack_min = 0; ack_max = 3;
    run(500);
    check_val("t6_resumed", svc_count != 0, 1);

    // Drain and quiet down.
    en_pct = 0; evt_pct = 0; pop_pct = 100; clr_pct = 0;
    run(40);
    check_val("final_log_valid", log_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cr_kme_int_servicer.md
Name: cr_kme_int_servicer

Overview:
- Hardware-side servicer for the KME interrupt, and the other end of the interrupt status/W1C protocol.
- On kme_interrupt it reads the interrupt status register over the register bus and logs the non-zero status with a timestamp in a small FIFO for firmware.
- It then writes the same bits back to the status register to clear them (write-1-to-clear).
- Sits between the KME interrupt handler/regfile and the management processor's event queue.

Parameters:
STATUS_W, 5, width of interrupt status field (bits [STATUS_W-1:0] of the status register)
ADDR_W, 16, register address width
INT_STATUS_ADDR, 16'h0040, address of the interrupt status register
LOG_DEPTH, 8, event log entries (power of 2, >=2)
TS_W, 32, timestamp width
HOLDOFF, 4, idle cycles after a clear before kme_interrupt is re-sampled (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  servicer enabled; when 0, no new service sequence is started
kme_interrupt  in  1  level interrupt from the handler
rd_stb  out  1  register read request, held until rd_ack
rd_ack  in  1  read data valid this cycle
rd_data  in  32  read data
wr_stb  out  1  register write request, held until wr_ack
wr_ack  in  1  write accepted this cycle
wr_data  out  32  write data (W1C mask)
reg_addr  out  ADDR_W  register address for rd_stb/wr_stb
log_valid  out  1  log FIFO non-empty
log_data  out  TS_W+STATUS_W  {timestamp, status} at FIFO head
log_pop  in  1  consume head entry; ignored when log is empty
log_overflow  out  1  sticky: an event was dropped because the log was full
log_overflow_clr  in  1  clears log_overflow
svc_count  out  16  number of non-zero status events serviced; saturates at 16'hFFFF

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, timestamp counter 0.
- Timestamp: free-running TS_W-bit counter, wraps to 0 after all-ones.
- FSM states: IDLE, RD_REQ, WR_REQ, HOLD.
- IDLE -> RD_REQ when enable & kme_interrupt.
  - RD_REQ drives rd_stb=1, reg_addr=INT_STATUS_ADDR.
- RD_REQ on rd_ack: capture st = rd_data[STATUS_W-1:0] and ts = the timestamp at the ack cycle.
  - If st != 0: push {ts,st} into the log, increment svc_count, go to WR_REQ.
  - If st == 0 (e.g. BIMC-only interrupt): no push, no write, go to HOLD.
- WR_REQ:
  - Drives wr_stb=1, reg_addr=INT_STATUS_ADDR, wr_data={zero-extend, st}.
  - Holds these values until wr_ack, then goes to HOLD.
  - Only captured bits are cleared; events arriving after the read stay set.
- HOLD: counts HOLDOFF cycles, then returns to IDLE. This covers the handler's registered-interrupt lag.
- Latency: an asserted interrupt seen in IDLE gives rd_stb in the next cycle. rd_stb and wr_stb are never high together.
- enable deasserted mid-sequence: the current sequence completes; the servicer waits in IDLE afterwards.
- FIFO:
  - Push is accepted if not full, or if full with log_pop in the same cycle.
  - Otherwise the new entry is dropped and log_overflow is set.
  - Simultaneous push and pop on empty: entry written, log_valid=1 next cycle.
  - log_data is valid whenever log_valid=1.
  - Pointers wrap modulo LOG_DEPTH; a count register distinguishes full from empty.
- Overflow flag: a set and log_overflow_clr in the same cycle leave the flag set (set wins).
- Reset mid-sequence: strobes drop immediately (async); no partial writes are retried.

Decomposition:
- Package cr_kme_int_svc_pkg holds:
  - FSM state enum
  - log entry typedef {ts, status}
  - INT_STATUS_ADDR default
- One sub-module: cr_kme_int_log_fifo, a parameterised sync FIFO with push/pop/full/empty/count, with the overflow policy kept in the parent.

Test Plan:
1. Reset, then kme_interrupt=1 with rd_data=32'h5 and ack after 2 cycles -> one log entry {ts_at_ack,5'h05}; write of wr_data=32'h5 to 16'h0040; svc_count=1; HOLD lasts 4 cycles.
2. rd_data=0 (BIMC-only interrupt) -> no log push, no wr_stb, svc_count unchanged, FSM passes through HOLD to IDLE.
3. 9 events with log_pop=0 (LOG_DEPTH=8) -> 8 entries in order, log_overflow=1. Pop once, then pulse log_overflow_clr -> flag=0, 7 entries left.
4. Log full with log_pop and push in the same cycle -> no overflow, count stays 8, head advances.
5. Interrupt held high after clear (new status bit 4'h8 set during WR_REQ) -> second read after HOLD returns 8, second entry logged, wr_data=8.
6. rst_n low while wr_stb is high awaiting wr_ack -> wr_stb=0 immediately, FIFO empty, svc_count=0; normal service resumes after release.
